// File: rtl/alu_pkg.sv
// Shared opcode/state types for iterative_alu.
// ALU_DIV_EN makes DIVU (4'b1111) a multi-cycle op; otherwise it is undecoded.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSll  = 4'b0001,
    OpSlt  = 4'b0010,
    OpSltu = 4'b0011,
    OpXor  = 4'b0100,
    OpSrl  = 4'b0101,
    OpOr   = 4'b0110,
    OpAnd  = 4'b0111,
    OpSub  = 4'b1000,
    OpSra  = 4'b1101,
    OpMul  = 4'b1110,
    OpDivu = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } alu_state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    logic multi;
    multi = (op == OpMul);
`ifdef ALU_DIV_EN
    if (op == OpDivu) multi = 1'b1;
`endif
    return multi;
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// WIDTH-iteration shift-add multiplier and (with ALU_DIV_EN) restoring divider.
// done is high during the last iteration cycle; result is that iteration's outcome.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic             busy_q;
  logic [CntW-1:0]  cnt_q;
  // mul: x = shifted multiplicand, y = shifted multiplier, acc = product
  // div: x = dividend shifting into quotient, y = divisor, acc = remainder
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
`ifdef ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
`endif

  assign done = busy_q && (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    acc_d = acc_q;
`ifdef ALU_DIV_EN
    rem_shift = {acc_q, x_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, y_q};
    if (div_q) begin
      // A zero divisor never underflows, so the quotient fills with ones.
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_shift[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], 1'b0};
      end
    end else
`endif
    begin
      if (y_q[0]) acc_d = acc_q + x_q;
      x_d = x_q << 1;
      y_d = y_q >> 1;
    end
  end

`ifdef ALU_DIV_EN
  assign result = div_q ? x_d : acc_d;
`else
  assign result = acc_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
`ifdef ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      x_q    <= a;
      y_q    <= b;
      acc_q  <= '0;
`ifdef ALU_DIV_EN
      div_q  <= is_div;
`endif
    end else if (busy_q) begin
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// RV32-style ALU with valid/ready handshakes; MUL (and DIVU under ALU_DIV_EN)
// run iteratively in alu_muldiv, everything else completes in one cycle.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALURes,
  output logic             zero
);

  localparam int unsigned ShW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] simple_res;
  logic [ShW-1:0]   shamt;
  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign ALURes    = res_q;
  assign zero      = zero_q;
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_multicycle(ALUOp);
  assign shamt     = B[ShW-1:0];

  always_comb begin
    simple_res = '0;
    case (ALUOp)
      OpAdd:   simple_res = A + B;
      OpSub:   simple_res = A - B;
      OpSll:   simple_res = A << shamt;
      OpSlt:   simple_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OpSltu:  simple_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OpXor:   simple_res = A ^ B;
      OpSrl:   simple_res = A >> shamt;
      OpSra:   simple_res = $unsigned($signed(A) >>> shamt);
      OpOr:    simple_res = A | B;
      OpAnd:   simple_res = A & B;
      default: simple_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_multicycle(ALUOp)) begin
            state_d = StBusy;
          end else begin
            state_d = StDone;
            res_d   = simple_res;
            zero_d  = (simple_res == '0);
          end
        end
      end
      StBusy: begin
        if (md_done) begin
          state_d = StDone;
          res_d   = md_result;
          zero_d  = (md_result == '0);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          zero_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
`ifdef ALU_DIV_EN
    .is_div (ALUOp == OpDivu),
`endif
    .a      (A),
    .b      (B),
    .done   (md_done),
    .result (md_result)
  );

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: directed table, handshake/reset corner
// sequences, random ops against an arithmetic reference, plus a WIDTH=8 instance.
module tb_iterative_alu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, zero;
  logic [W-1:0] A, B, ALURes;
  logic [3:0]   ALUOp;

  logic         in_valid8, in_ready8, out_valid8, out_ready8, zero8;
  logic [7:0]   a8, b8, res8;
  logic [3:0]   op8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iterative_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUOp     (ALUOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALURes    (ALURes),
    .zero      (zero)
  );

  iterative_alu #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .A         (a8),
    .B         (b8),
    .ALUOp     (op8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .ALURes    (res8),
    .zero      (zero8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [63:0] p;
    sh = b % 32;
    p  = 64'(a) * 64'(b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return $signed(a) >>> sh;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1110: return p[31:0];
`ifdef ALU_DIV_EN
      4'b1111: return (b == 0) ? 32'hFFFF_FFFF : a / b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    if (op == 4'b1110) return W + 1;
`ifdef ALU_DIV_EN
    if (op == 4'b1111) return W + 1;
`endif
    return 1;
  endfunction

  // Issue one op, scramble inputs while it runs, hold the result for `hold`
  // cycles of backpressure, then release it and check the return to idle.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input int el, input int hold);
    int   lat;
    logic rdy_seen;
    check("in_ready_idle", in_ready, 1);
    A = a; B = b; ALUOp = op; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < int'(W) + 5) begin
      if (in_ready) rdy_seen = 1'b1;
      in_valid = 1'($urandom_range(0, 1)); A = $urandom; B = $urandom; ALUOp = 4'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, el);
    check("in_ready_busy", rdy_seen, 0);
    check("result", ALURes, er);
    check("zero", zero, ez);
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1)); A = $urandom; B = $urandom; ALUOp = 4'($urandom);
      @(posedge clk); #1;
      check("hold", {out_valid, zero, ALURes}, {1'b1, ez, er});
    end
    out_ready = 1'b1; in_valid = 1'b1; A = $urandom; B = $urandom; ALUOp = 4'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("release", {out_valid, zero, in_ready, ALURes}, {1'b0, 1'b0, 1'b1, er});
  endtask

  task automatic do_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input int el);
    int lat;
    check("w8_in_ready", in_ready8, 1);
    a8 = a; b8 = b; op8 = op; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8_latency", lat, el);
    check("w8_result", res8, er);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("w8_release", {out_valid8, in_ready8}, 2'b01);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb, rr;
    logic        ov_seen;

    vecs.push_back('{4'b0000, 32'd1, 32'd8, 32'd9, 1'b0, 1});
    vecs.push_back('{4'b1000, 32'd4, 32'd2, 32'd2, 1'b0, 1});
    vecs.push_back('{4'b0100, 32'd4, 32'd1, 32'd5, 1'b0, 1});
    vecs.push_back('{4'b1000, 32'd5, 32'd5, 32'd0, 1'b1, 1});
    vecs.push_back('{4'b1110, 32'd4, 32'd2, 32'd8, 1'b0, 33});
    vecs.push_back('{4'b1110, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 33});
    vecs.push_back('{4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1});
    vecs.push_back('{4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1});
    vecs.push_back('{4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1});
    vecs.push_back('{4'b0001, 32'd1, 32'd33, 32'd2, 1'b0, 1});
    vecs.push_back('{4'b0101, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1});
    vecs.push_back('{4'b1001, 32'd7, 32'd3, 32'd0, 1'b1, 1});
    vecs.push_back('{4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1});
`ifdef ALU_DIV_EN
    vecs.push_back('{4'b1111, 32'd100, 32'd7, 32'd14, 1'b0, 33});
    vecs.push_back('{4'b1111, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 33});
`else
    vecs.push_back('{4'b1111, 32'd100, 32'd7, 32'd0, 1'b1, 1});
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALUOp = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {out_valid, zero, in_ready, ALURes}, {1'b0, 1'b0, 1'b1, 32'd0});
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z, vecs[i].lat,
            $urandom_range(0, 2));

    // Backpressure: result held for 5 cycles while in_valid toggles.
    do_op(4'b0000, 32'd3, 32'd4, 32'd7, 1'b0, 1, 5);

    // Reset in the middle of a multiply: aborted result must never surface.
    A = 32'd4; B = 32'd2; ALUOp = 4'b1110; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_mul_busy", {in_ready, out_valid}, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_mul_reset", {out_valid, zero, in_ready, ALURes}, {1'b0, 1'b0, 1'b1, 32'd0});
    ov_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen = 1'b1;
    end
    check("aborted_mul_silent", ov_seen, 0);
    do_op(4'b0000, 32'd2, 32'd2, 32'd4, 1'b0, 1, 0);

    // Reset while holding a result in DONE, with out_ready asserted.
    A = 32'd9; B = 32'd9; ALUOp = 4'b0000; in_valid = 1'b1;
    @(posedge clk); #1;
    check("done_before_reset", {out_valid, ALURes}, {1'b1, 32'd18});
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("reset_in_done", {out_valid, zero, in_ready, ALURes}, {1'b0, 1'b0, 1'b1, 32'd0});

    // Random ops against the reference model.
    repeat (150) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rr  = ref_alu(rop, ra, rb);
      do_op(rop, ra, rb, rr, (rr == 0), ref_lat(rop), $urandom_range(0, 1));
    end

    // WIDTH=8 instance.
    do_op8(4'b1110, 8'd16, 8'd17, 8'h10, 9);
    do_op8(4'b1101, 8'h80, 8'd1, 8'hC0, 1);
    do_op8(4'b0000, 8'hFF, 8'd2, 8'h01, 1);
    do_op8(4'b1110, 8'hFF, 8'hFF, 8'h01, 9);
    do_op8(4'b0001, 8'h01, 8'd9, 8'h02, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
